// File: rtl/ram_arb_pkg.sv
// Shared defaults and the RAM command type for the round-robin RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_NREQ = 2;
  localparam int unsigned DEF_AW   = 4;
  localparam int unsigned DEF_DW   = 8;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } ram_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_NREQ,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic        w_found;
  int unsigned w_cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_cand = 32'(ptr_i) + i;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!w_found && req_i[w_cand[IW-1:0]]) begin
        w_found                  = 1'b1;
        gnt_o[w_cand[IW-1:0]]    = 1'b1;
        idx_o                    = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin master of a single-port synchronous RAM: registers the winning command onto
// the RAM port and returns read data two cycles after the grant, tagged to the requester.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               ram_wr,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_din,
  input  logic [DW-1:0]      ram_dout
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_idx;
  logic [NREQ-1:0] w_gnt;
  logic            w_any;
  cmd_t            w_cmd;
  cmd_t            r_cmd;
  logic            r_s1_vld, r_s2_vld;
  logic [IW-1:0]   r_s1_id,  r_s2_id;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (r_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_idx)
  );

  assign w_any = |w_gnt;
  assign gnt_o = rst_n ? w_gnt : '0;

  always_comb begin
    w_cmd.we   = we_i[w_idx];
    w_cmd.addr = addr_i[32'(w_idx)*AW +: AW];
    w_cmd.data = wdata_i[32'(w_idx)*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_cmd    <= '0;
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= '0;
    end else begin
      if (w_any) begin
        r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        r_cmd <= w_cmd;
      end else begin
        // Idle: stop writing but keep address/data stable on the RAM pins.
        r_cmd.we <= 1'b0;
      end
      r_s1_vld <= w_any & ~w_cmd.we;
      r_s1_id  <= w_idx;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (r_s2_vld) rvalid_o[r_s2_id] = 1'b1;
  end

  assign rdata_o  = ram_dout;
  assign ram_wr   = r_cmd.we;
  assign ram_addr = r_cmd.addr;
  assign ram_din  = r_cmd.data;

endmodule
